// File: rtl/cc_mem_rd_responder.sv
// Memory-side AXI read slave for the cache-controller miss path: queued AR requests, WRAP/INCR/FIXED
// beats after a fixed latency, data derived from beat address. Define MEM_RD_STALL_EN for LFSR-driven rvalid gaps.
module cc_mem_rd_responder #(
   parameter int          AR_FIFO_DEPTH = 4,
   parameter int          RD_LATENCY    = 4,
   parameter logic [31:0] DATA_SEED     = 32'hA5A5_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  arid_i,
   input  logic [31:0] araddr_i,
   input  logic [3:0]  arlen_i,
   input  logic [2:0]  arsize_i,
   input  logic [1:0]  arburst_i,
   input  logic        arvalid_i,
   output logic        arready_o,
   output logic [3:0]  rid_o,
   output logic [63:0] rdata_o,
   output logic [1:0]  rresp_o,
   output logic        rlast_o,
   output logic        rvalid_o,
   input  logic        rready_i
);

   // state  | meaning
   // IDLE   | no burst in service; pops the FIFO head when one is queued
   // WAIT   | latency countdown before the first beat
   // BURST  | presenting beats until the rlast handshake
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST} state_t;

   localparam int             LP_PW       = (AR_FIFO_DEPTH > 1) ? $clog2(AR_FIFO_DEPTH) : 1;
   localparam int             LP_EW       = 45;
   localparam logic [LP_PW:0] LP_FULL     = (LP_PW + 1)'(AR_FIFO_DEPTH);
   localparam logic [7:0]     LP_LAT_LOAD = (RD_LATENCY > 0) ? 8'(RD_LATENCY - 1) : 8'd0;

   logic [LP_EW-1:0] r_fifo [AR_FIFO_DEPTH];
   logic [LP_PW-1:0] r_wr_ptr;
   logic [LP_PW-1:0] r_rd_ptr;
   logic [LP_PW:0]   r_count;
   logic [LP_PW:0]   w_count_nxt;
   logic             r_arready;
   logic             w_push;
   logic             w_pop;
   logic [LP_EW-1:0] w_head;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_id;
   logic [31:0] r_addr;
   logic [3:0]  r_len;
   logic [1:0]  r_burst;
   logic [1:0]  r_resp;
   logic [7:0]  r_lat;
   logic [3:0]  r_beat;

   logic        w_rvalid;
   logic        w_hs;
   logic        w_last;
   logic        w_err;
   logic [31:0] w_base;
   logic [31:0] w_beat_addr;
   logic        w_unused_addr_lsb;

   assign w_push      = arvalid_i & r_arready;
   assign w_count_nxt = r_count + (LP_PW + 1)'(w_push) - (LP_PW + 1)'(w_pop);
   assign w_head      = r_fifo[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= {arid_i, araddr_i, arlen_i, arsize_i, arburst_i};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_arready <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + LP_PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_PW'(1);
         r_count   <= w_count_nxt;
         r_arready <= (w_count_nxt != LP_FULL);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_count != '0) begin
               w_pop       = 1'b1;
               w_state_nxt = (RD_LATENCY == 0) ? ST_BURST : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_lat == 8'd0) w_state_nxt = ST_BURST;
         end
         ST_BURST: begin
            if (w_hs && w_last) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Only full-width INCR and full-line WRAP are legal line fills.
   assign w_err = !((w_head[4:2] == 3'b011) &&
                    ((w_head[1:0] == 2'b01) || ((w_head[1:0] == 2'b10) && (w_head[8:5] == 4'd7))));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_burst <= '0;
         r_resp  <= '0;
         r_lat   <= '0;
         r_beat  <= '0;
      end else if (w_pop) begin
         r_id    <= w_head[44:41];
         r_addr  <= w_head[40:9];
         r_len   <= w_head[8:5];
         r_burst <= w_head[1:0];
         r_resp  <= w_err ? 2'b10 : 2'b00;
         r_lat   <= LP_LAT_LOAD;
         r_beat  <= '0;
      end else begin
         if ((r_state == ST_WAIT) && (r_lat != 8'd0)) r_lat <= r_lat - 8'd1;
         if (w_hs) r_beat <= r_beat + 4'd1;
      end
   end

`ifdef MEM_RD_STALL_EN
   logic [7:0] r_lfsr;
   logic       r_held;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= 8'hA1;
         r_held <= 1'b0;
      end else begin
         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
         r_held <= w_rvalid & ~rready_i;
      end
   end

   // A beat already on the bus stays up until taken, whatever the LFSR says.
   assign w_rvalid = (r_state == ST_BURST) & (r_held | ~r_lfsr[0]);
`else
   assign w_rvalid = (r_state == ST_BURST);
`endif

   assign w_hs   = w_rvalid & rready_i;
   assign w_last = (r_beat == r_len);
   assign w_base = {r_addr[31:3], 3'b000};

   always_comb begin
      w_beat_addr = w_base;
      case (r_burst)
         2'b10:   w_beat_addr = {r_addr[31:6], r_addr[5:3] + r_beat[2:0], 3'b000};
         2'b01:   w_beat_addr = w_base + {25'd0, r_beat, 3'b000};
         default: w_beat_addr = w_base;
      endcase
   end

   assign w_unused_addr_lsb = ^r_addr[2:0];

   assign arready_o = r_arready;
   assign rvalid_o  = w_rvalid;
   assign rlast_o   = w_rvalid & w_last;
   assign rid_o     = r_id;
   assign rresp_o   = r_resp;
   assign rdata_o   = w_rvalid ? {w_beat_addr, w_beat_addr ^ DATA_SEED} : 64'd0;

endmodule

// File: tb/tb_cc_mem_rd_responder.sv
// Directed bench for cc_mem_rd_responder (default build, RD_LATENCY=4, AR_FIFO_DEPTH=4).
module tb_cc_mem_rd_responder;

   localparam logic [31:0] SEED = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  arid_i;
   logic [31:0] araddr_i;
   logic [3:0]  arlen_i;
   logic [2:0]  arsize_i;
   logic [1:0]  arburst_i;
   logic        arvalid_i;
   logic        arready_o;
   logic [3:0]  rid_o;
   logic [63:0] rdata_o;
   logic [1:0]  rresp_o;
   logic        rlast_o;
   logic        rvalid_o;
   logic        rready_i;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_a [16];
   logic        ar_pending = 1'b0;
   logic        ar_drop    = 1'b0;
   logic        ar_taken   = 1'b0;
   int          first_cyc;
   int          vcnt;

   cc_mem_rd_responder #(
      .AR_FIFO_DEPTH(4),
      .RD_LATENCY   (4),
      .DATA_SEED    (SEED)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .arid_i   (arid_i),
      .araddr_i (araddr_i),
      .arlen_i  (arlen_i),
      .arsize_i (arsize_i),
      .arburst_i(arburst_i),
      .arvalid_i(arvalid_i),
      .arready_o(arready_o),
      .rid_o    (rid_o),
      .rdata_o  (rdata_o),
      .rresp_o  (rresp_o),
      .rlast_o  (rlast_o),
      .rvalid_o (rvalid_o),
      .rready_i (rready_i)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Entered and left at #1 after a rising edge; the handshake edge is the end of "cycle 0".
   task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n;
      arid_i = id; araddr_i = a; arlen_i = len; arsize_i = size; arburst_i = burst;
      arvalid_i = 1'b1;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (arready_o) break;
         @(posedge clk); #1;
      end
      check($sformatf("ar_accept id%0d", id), 72'(n < 200), 72'(1));
      @(posedge clk); #1;
      arvalid_i = 1'b0;
   endtask

   // mode 0: rready always 1; mode 1: rready pattern 1,0,0 repeating.
   task automatic recv_burst(input string tag, input logic [3:0] id, input logic [3:0] len,
                             input logic [1:0] resp, input int mode, input int stop_after,
                             output int first);
      int          beats;
      int          c;
      logic        stalled;
      logic [70:0] prev;
      logic [70:0] cur;
      beats = 0; c = 0; first = -1; stalled = 1'b0; prev = '0;
      while (beats <= int'(len) && beats != stop_after && c < 300) begin
         c++;
         rready_i = (mode == 0) ? 1'b1 : ((c % 3) == 1);
         @(negedge clk);
         cur = {rid_o, rdata_o, rresp_o, rlast_o};
         if (stalled) check($sformatf("%s stall_hold beat%0d", tag, beats), {rvalid_o, cur}, {1'b1, prev});
         if (rvalid_o) begin
            if (first < 0) first = c;
            check($sformatf("%s rdata beat%0d", tag, beats), 72'(rdata_o),
                  72'({exp_a[beats], exp_a[beats] ^ SEED}));
            check($sformatf("%s rid beat%0d", tag, beats), 72'(rid_o), 72'(id));
            check($sformatf("%s rresp beat%0d", tag, beats), 72'(rresp_o), 72'(resp));
            check($sformatf("%s rlast beat%0d", tag, beats), 72'(rlast_o), 72'(beats == int'(len)));
            if (rready_i) beats++;
         end
         stalled = rvalid_o & ~rready_i;
         prev = cur;
         if (ar_pending && arready_o) ar_drop = 1'b1;
         @(posedge clk); #1;
         if (ar_drop) begin
            arvalid_i = 1'b0; ar_pending = 1'b0; ar_drop = 1'b0; ar_taken = 1'b1;
         end
      end
      check($sformatf("%s beat_count", tag), 72'(beats),
            72'((stop_after < 0) ? int'(len) + 1 : stop_after));
   endtask

   initial begin
      rst_n = 1'b0; arid_i = '0; araddr_i = '0; arlen_i = '0; arsize_i = '0; arburst_i = '0;
      arvalid_i = 1'b0; rready_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset outputs", {arready_o, rvalid_o, rlast_o, rid_o, rdata_o, rresp_o}, 72'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("arready before first edge", 72'(arready_o), 72'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("arready after release", 72'(arready_o), 72'(1));
      @(posedge clk); #1;

      // Critical-word-first WRAP fill, first beat in cycle RD_LATENCY+2.
      exp_a[0] = 32'h0000_1018; exp_a[1] = 32'h0000_1020; exp_a[2] = 32'h0000_1028; exp_a[3] = 32'h0000_1030;
      exp_a[4] = 32'h0000_1038; exp_a[5] = 32'h0000_1000; exp_a[6] = 32'h0000_1008; exp_a[7] = 32'h0000_1010;
      send_ar(4'd5, 32'h0000_1018, 4'd7, 3'd3, 2'b10);
      recv_burst("wrap", 4'd5, 4'd7, 2'b00, 0, -1, first_cyc);
      check("wrap first rvalid cycle", 72'(first_cyc), 72'(6));

      send_ar(4'd5, 32'h0000_1018, 4'd7, 3'd3, 2'b10);
      recv_burst("backpressure", 4'd5, 4'd7, 2'b00, 1, -1, first_cyc);

      exp_a[0] = 32'h40; exp_a[1] = 32'h40; exp_a[2] = 32'h40; exp_a[3] = 32'h40;
      send_ar(4'd3, 32'h0000_0044, 4'd3, 3'd3, 2'b00);
      recv_burst("fixed_err", 4'd3, 4'd3, 2'b10, 0, -1, first_cyc);

      exp_a[0] = 32'h100; exp_a[1] = 32'h108; exp_a[2] = 32'h110; exp_a[3] = 32'h118;
      send_ar(4'd4, 32'h0000_0100, 4'd3, 3'd3, 2'b10);
      recv_burst("wrap4_err", 4'd4, 4'd3, 2'b10, 0, -1, first_cyc);

      exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'h0000_0000;
      send_ar(4'd7, 32'hFFFF_FFF8, 4'd1, 3'd3, 2'b01);
      recv_burst("incr_top", 4'd7, 4'd1, 2'b00, 0, -1, first_cyc);

      // Queue full: id1 pops straight into service, id2..id5 then fill the four entries.
      rready_i = 1'b0;
      for (int k = 1; k <= 5; k++) send_ar(4'(k), 32'h0000_2000 * k, 4'd1, 3'd3, 2'b01);
      @(negedge clk);
      check("arready full", 72'(arready_o), 72'(0));
      @(posedge clk); #1;
      arid_i = 4'd6; araddr_i = 32'h0000_C000; arlen_i = 4'd1; arsize_i = 3'd3; arburst_i = 2'b01;
      arvalid_i = 1'b1; ar_pending = 1'b1; ar_taken = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("arready held low while full", 72'(arready_o), 72'(0));
      @(posedge clk); #1;
      exp_a[0] = 32'h0000_2000; exp_a[1] = 32'h0000_2008;
      recv_burst("queue id1", 4'd1, 4'd1, 2'b00, 0, -1, first_cyc);
      check("id6 not accepted during burst1", 72'(ar_taken), 72'(0));
      for (int k = 2; k <= 6; k++) begin
         exp_a[0] = (k == 6) ? 32'h0000_C000 : 32'h0000_2000 * k;
         exp_a[1] = exp_a[0] + 32'd8;
         recv_burst($sformatf("queue id%0d", k), 4'(k), 4'd1, 2'b00, 0, -1, first_cyc);
         if (k == 2) check("id6 accepted after pop", 72'(ar_taken), 72'(1));
      end

      // Reset mid-burst with two requests still queued.
      rready_i = 1'b0;
      send_ar(4'd9,  32'h0000_1018, 4'd7, 3'd3, 2'b10);
      send_ar(4'd10, 32'h0000_4000, 4'd1, 3'd3, 2'b01);
      send_ar(4'd11, 32'h0000_5000, 4'd1, 3'd3, 2'b01);
      exp_a[0] = 32'h0000_1018; exp_a[1] = 32'h0000_1020; exp_a[2] = 32'h0000_1028;
      recv_burst("pre_reset", 4'd9, 4'd7, 2'b00, 0, 3, first_cyc);
      rst_n = 1'b0;
      #1;
      check("mid-burst reset outputs", {arready_o, rvalid_o, rlast_o, rid_o, rdata_o, rresp_o}, 72'd0);
      @(negedge clk);
      check("reset held outputs", {arready_o, rvalid_o, rlast_o, rid_o, rdata_o, rresp_o}, 72'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("arready after second release", 72'(arready_o), 72'(1));
      vcnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rvalid_o) vcnt++;
      end
      check("no stale beats", 72'(vcnt), 72'(0));
      @(posedge clk); #1;
      exp_a[0] = 32'h0000_3000;
      send_ar(4'd12, 32'h0000_3000, 4'd0, 3'd3, 2'b01);
      recv_burst("post_reset", 4'd12, 4'd0, 2'b00, 0, -1, first_cyc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
